// File: rtl/act_pkg.sv
// Shared definitions for the activation unit: mode encoding, default Q-format
// widths and the round-half-up / saturate helper used by the leaky path.
package act_pkg;

    localparam int ACT_DATA_W = 16;
    localparam int ACT_FRAC_W = 8;
    localparam int ACT_CNT_W  = 32;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'b00,
        ACT_RELU   = 2'b01,
        ACT_LEAKY  = 2'b10,
        ACT_CLAMP  = 2'b11
    } act_mode_e;

    // Works on a 64-bit sign-extended product so one helper serves any
    // DATA_W up to 32; the caller narrows the already-saturated result.
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] p,
        input int                 data_w,
        input int                 frac_w
    );
        logic signed [63:0] half_v;
        logic signed [63:0] r_v;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        half_v = 64'sd1 <<< (frac_w - 1);
        r_v    = (p + half_v) >>> frac_w;
        max_v  = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        min_v  = -(64'sd1 <<< (data_w - 1));
        if (r_v > max_v) begin
            round_sat = max_v;
        end else if (r_v < min_v) begin
            round_sat = min_v;
        end else begin
            round_sat = r_v;
        end
    endfunction

endpackage

// File: rtl/act_unit_pipe_if.sv
// Beat-level bus of the activation unit. The master side feeds beats and
// drains results; the slave side is the activation pipeline itself.
interface act_unit_pipe_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32
);

    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   in_data;
    logic [1:0]                mode_in;
    logic [DATA_W-1:0]         leak_in;
    logic [DATA_W-1:0]         clip_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*DATA_W-1:0]   out_data;
    logic                      stats_clr_in;
    logic [CNT_W-1:0]          neg_count_out;

    modport master (
        output in_valid, in_data, mode_in, leak_in, clip_in,
        output out_ready, stats_clr_in,
        input  in_ready, out_valid, out_data, neg_count_out
    );

    modport slave (
        input  in_valid, in_data, mode_in, leak_in, clip_in,
        input  out_ready, stats_clr_in,
        output in_ready, out_valid, out_data, neg_count_out
    );

endinterface

// File: rtl/act_lane.sv
// One activation lane: stage 1 captures x and the full-width x*leak product,
// stage 2 applies the selected activation and holds the lane result.
module act_lane
    import act_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W,
    parameter int FRAC_W = ACT_FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s1_load,
    input  logic              s2_load,
    input  logic              s1_valid,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] leak_in,
    input  act_mode_e         mode,
    input  logic [DATA_W-1:0] clip,
    output logic [DATA_W-1:0] y_out
);

    logic signed [DATA_W-1:0]   x_d, x_q;
    logic signed [2*DATA_W-1:0] p_d, p_q;
    logic signed [DATA_W-1:0]   y_d, y_q;

    logic signed [DATA_W-1:0]   clip_s;
    logic signed [DATA_W-1:0]   clip_eff;
    logic signed [DATA_W-1:0]   r_sat;
    logic signed [DATA_W-1:0]   y_fn;
    logic                       x_neg;

    always_comb begin
        x_d = x_q;
        p_d = p_q;
        if (s1_load) begin
            x_d = $signed(x_in);
            p_d = $signed(x_in) * $signed(leak_in);
        end
    end

    // A negative clamp limit is meaningless for a ReLU-style clamp, so it
    // collapses to zero and the lane output becomes all zeros.
    always_comb begin
        clip_s   = $signed(clip);
        clip_eff = (clip_s < 0) ? '0 : clip_s;
        x_neg    = x_q[DATA_W-1];
        r_sat    = DATA_W'(round_sat(64'(p_q), DATA_W, FRAC_W));
        case (mode)
            ACT_BYPASS: y_fn = x_q;
            ACT_RELU:   y_fn = x_neg ? '0 : x_q;
            ACT_LEAKY:  y_fn = x_neg ? r_sat : x_q;
            ACT_CLAMP:  y_fn = x_neg ? '0 : ((x_q > clip_eff) ? clip_eff : x_q);
            default:    y_fn = x_q;
        endcase
    end

    always_comb begin
        y_d = y_q;
        if (s2_load) begin
            y_d = s1_valid ? y_fn : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            p_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            p_q <= p_d;
            y_q <= y_d;
        end
    end

    assign y_out = y_q;

endmodule

// File: rtl/act_unit_pipe.sv
// Multi-lane 2-stage activation pipeline with valid/ready backpressure.
// Optional negative-lane statistics counter enabled by `define ACT_STATS_EN.
module act_unit_pipe
    import act_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = ACT_DATA_W,
    parameter int FRAC_W = ACT_FRAC_W,
    parameter int CNT_W  = ACT_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    act_unit_pipe_if.slave bus
);

    logic                    s2_adv;
    logic                    s1_adv;
    logic                    in_fire;
    logic                    s1_valid_d, s1_valid_q;
    logic                    s2_valid_d, s2_valid_q;
    act_mode_e               mode_d, mode_q;
    logic [DATA_W-1:0]       clip_d, clip_q;
    logic [LANES*DATA_W-1:0] lane_y;

    // Each stage may move whenever the stage after it can take its contents,
    // so a full pipe still accepts a new beat on the cycle the output drains.
    always_comb begin
        s2_adv  = !s2_valid_q || bus.out_ready;
        s1_adv  = !s1_valid_q || s2_adv;
        in_fire = bus.in_valid && s1_adv;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        mode_d     = mode_q;
        clip_d     = clip_q;
        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (in_fire) begin
            mode_d = act_mode_e'(bus.mode_in);
            clip_d = bus.clip_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            mode_q     <= ACT_BYPASS;
            clip_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            mode_q     <= mode_d;
            clip_q     <= clip_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .s1_load  (in_fire),
            .s2_load  (s2_adv),
            .s1_valid (s1_valid_q),
            .x_in     (bus.in_data[g*DATA_W +: DATA_W]),
            .leak_in  (bus.leak_in),
            .mode     (mode_q),
            .clip     (clip_q),
            .y_out    (lane_y[g*DATA_W +: DATA_W])
        );
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = lane_y;

`ifdef ACT_STATS_EN
    localparam int NEG_W = $clog2(LANES + 1);

    logic [NEG_W-1:0] beat_neg;
    logic [NEG_W-1:0] add_neg;
    logic [CNT_W:0]   neg_sum;
    logic [CNT_W-1:0] neg_count_d, neg_count_q;

    // A clear that lands on a transfer still counts that beat, so no
    // negative lane is ever lost across a clear.
    always_comb begin
        beat_neg = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_neg = beat_neg + NEG_W'(bus.in_data[i*DATA_W + DATA_W - 1]);
        end
        add_neg = in_fire ? beat_neg : '0;
        neg_sum = {1'b0, neg_count_q} + (CNT_W + 1)'(add_neg);
        if (bus.stats_clr_in) begin
            neg_count_d = CNT_W'(add_neg);
        end else if (neg_sum[CNT_W]) begin
            neg_count_d = '1;
        end else begin
            neg_count_d = neg_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_count_q <= '0;
        end else begin
            neg_count_q <= neg_count_d;
        end
    end

    assign bus.neg_count_out = neg_count_q;
`else
    assign bus.neg_count_out = '0;
`endif

endmodule

// File: tb/tb_act_unit_pipe.sv
// Scoreboard bench for act_unit_pipe: a monitor pushes model results on each
// accepted beat and pops/compares them on each emitted beat.
module tb_act_unit_pipe;

    localparam int LANES  = 4;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 32;

    logic clk;
    logic rst;

    act_unit_pipe_if #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    act_unit_pipe #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .FRAC_W (8),
        .CNT_W  (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          compareCount = 0;
    int          errorCount   = 0;
    int          acceptCount  = 0;
    int          outCount     = 0;
    logic [63:0] sb[$];
    logic        holdValid    = 1'b0;
    logic [63:0] holdData     = '0;
    logic        stimDone     = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference activation computed directly from the Q8.8 definitions.
    function automatic logic [63:0] expectedBeat(input logic [63:0] data, input logic [1:0] mode,
                                                 input logic [15:0] leak, input logic [15:0] clip);
        logic [63:0] res;
        longint      x, lk, c, y;
        logic [15:0] lane;
        res = '0;
        lk  = longint'($signed(leak));
        c   = longint'($signed(clip));
        if (c < 0) c = 0;
        for (int i = 0; i < LANES; i++) begin
            lane = data[i*16 +: 16];
            x    = longint'($signed(lane));
            case (mode)
                2'b00: y = x;
                2'b01: y = (x < 0) ? 0 : x;
                2'b10: begin
                    if (x >= 0) begin
                        y = x;
                    end else begin
                        y = (x * lk + 128) >>> 8;
                        if (y > 32767) y = 32767;
                        if (y < -32768) y = -32768;
                    end
                end
                default: y = (x < 0) ? 0 : ((x > c) ? c : x);
            endcase
            res[i*16 +: 16] = y[15:0];
        end
        return res;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            holdValid = 1'b0;
        end else begin
            if (holdValid) begin
                checkOutput("stall_valid", {63'd0, bus.out_valid}, 64'd1);
                checkOutput("stall_data", bus.out_data, holdData);
            end
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    holdValid = 1'b0;
                    outCount++;
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_out", {63'd0, bus.out_valid}, 64'd0);
                    end else begin
                        checkOutput("sb_data", bus.out_data, sb.pop_front());
                    end
                end else begin
                    holdValid = 1'b1;
                    holdData  = bus.out_data;
                end
            end else begin
                holdValid = 1'b0;
                checkOutput("idle_zero", bus.out_data, 64'd0);
            end
            if (bus.in_valid && bus.in_ready) begin
                acceptCount++;
                sb.push_back(expectedBeat(bus.in_data, bus.mode_in, bus.leak_in, bus.clip_in));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic [63:0] data, input logic [1:0] mode,
                                 input logic [15:0] leak, input logic [15:0] clip);
        int   waitCycles;
        logic took;
        waitCycles   = 0;
        took         = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.mode_in  = mode;
        bus.leak_in  = leak;
        bus.clip_in  = clip;
        while (!took && waitCycles < 100) begin
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
            waitCycles++;
        end
        bus.in_valid = 1'b0;
        checkOutput("accept", {63'd0, took}, 64'd1);
    endtask

    task automatic waitOutput(output logic [63:0] data);
        int waitCycles;
        waitCycles = 0;
        data = '0;
        while (waitCycles < 20) begin
            @(negedge clk);
            if (bus.out_valid) begin
                data = bus.out_data;
                break;
            end
            waitCycles++;
        end
        checkOutput("out_seen", {63'd0, bus.out_valid}, 64'd1);
    endtask

    initial begin
        logic [63:0] got;
        int          base;
        int          w;

        rst              = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.mode_in      = 2'b00;
        bus.leak_in      = '0;
        bus.clip_in      = '0;
        bus.out_ready    = 1'b1;
        bus.stats_clr_in = 1'b0;
        #1;
        checkOutput("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("rst_out_data", bus.out_data, 64'd0);
        checkOutput("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        checkOutput("rst_neg_count", {32'd0, bus.neg_count_out}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] leaky latency");
        applyStimulus(64'h0100_0100_0100_FE00, 2'b10, 16'h001A, 16'h0000);
        @(negedge clk);
        checkOutput("lat_cycle1_valid", {63'd0, bus.out_valid}, 64'd0);
        @(negedge clk);
        checkOutput("lat_cycle2_valid", {63'd0, bus.out_valid}, 64'd1);
        checkOutput("leaky_data", bus.out_data, 64'h0100_0100_0100_FFCC);
        @(negedge clk);
        checkOutput("lat_pulse_end", {63'd0, bus.out_valid}, 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] clamp and saturation");
        applyStimulus(64'h0600_FF00_0080_0700, 2'b11, 16'h0000, 16'h0600);
        waitOutput(got);
        checkOutput("clamp_pos", got, 64'h0600_0000_0080_0600);
        @(posedge clk);
        #1;
        applyStimulus(64'h0600_FF00_0080_0700, 2'b11, 16'h0000, 16'hFF00);
        waitOutput(got);
        checkOutput("clamp_negclip", got, 64'h0000_0000_0000_0000);
        @(posedge clk);
        #1;
        applyStimulus(64'h0000_0000_0000_8000, 2'b10, 16'h8000, 16'h0000);
        waitOutput(got);
        checkOutput("leaky_sat", got, 64'h0000_0000_0000_7FFF);
        @(posedge clk);
        #1;

        $display("[TB] mixed modes back to back");
        applyStimulus(64'hFF00_0200_8000_0100, 2'b00, 16'h0080, 16'h0100);
        applyStimulus(64'hFF00_0200_8000_0100, 2'b01, 16'h0080, 16'h0100);
        applyStimulus(64'hFF00_0200_8000_0100, 2'b10, 16'h0080, 16'h0100);
        applyStimulus(64'hFF00_0200_8000_0100, 2'b11, 16'h0080, 16'h0100);

        $display("[TB] backpressure");
        repeat (4) @(posedge clk);
        #1;
        base          = acceptCount;
        bus.out_ready = 1'b0;
        fork
            begin
                applyStimulus(64'h0001_0002_0003_0004, 2'b00, 16'h0000, 16'h0000);
                applyStimulus(64'h0011_0012_0013_0014, 2'b01, 16'h0000, 16'h0000);
                applyStimulus(64'hFFF0_0022_0023_0024, 2'b10, 16'h0040, 16'h0000);
                applyStimulus(64'h0031_0F00_0033_0034, 2'b11, 16'h0000, 16'h0100);
            end
            begin
                repeat (3) @(negedge clk);
                checkOutput("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
                checkOutput("bp_accepted", 64'(acceptCount - base), 64'd2);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        base = outCount;
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput("bp_drained", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] reset mid-stream");
        bus.out_ready = 1'b0;
        applyStimulus(64'h1111_2222_3333_4444, 2'b00, 16'h0000, 16'h0000);
        applyStimulus(64'h5555_6666_7777_8888, 2'b00, 16'h0000, 16'h0000);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("midrst_out_data", bus.out_data, 64'd0);
        checkOutput("midrst_neg_count", {32'd0, bus.neg_count_out}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        base = outCount;
        repeat (5) begin
            @(negedge clk);
            checkOutput("post_rst_quiet", {63'd0, bus.out_valid}, 64'd0);
        end
        checkOutput("post_rst_no_out", 64'(outCount - base), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] statistics");
        applyStimulus(64'hFF00_0100_8000_0001, 2'b00, 16'h0000, 16'h0000);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 16'h0000, 16'h0000);
        applyStimulus(64'h0000_0000_0000_F000, 2'b00, 16'h0000, 16'h0000);
`ifdef ACT_STATS_EN
        checkOutput("neg_count_sum", {32'd0, bus.neg_count_out}, 64'd7);
`else
        checkOutput("neg_count_off", {32'd0, bus.neg_count_out}, 64'd0);
`endif
        bus.stats_clr_in = 1'b1;
        applyStimulus(64'hF000_F000_F000_0000, 2'b00, 16'h0000, 16'h0000);
        bus.stats_clr_in = 1'b0;
`ifdef ACT_STATS_EN
        checkOutput("neg_count_clr", {32'd0, bus.neg_count_out}, 64'd3);
`else
        checkOutput("neg_count_clr_off", {32'd0, bus.neg_count_out}, 64'd0);
`endif

        $display("[TB] random traffic");
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    applyStimulus({$urandom, $urandom}, 2'($urandom_range(0, 3)),
                                  16'($urandom), 16'($urandom));
                end
                stimDone = 1'b1;
            end
            begin
                while (!stimDone) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
        $finish;
    end

endmodule
